// File: rtl/imem_pkg.sv
// Shared types and constants for the byte-wide instruction-memory fetch sequencer.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } state_e;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned IMEM_ADDR_W = 6;
  localparam int unsigned ISSUE_W     = $clog2(INSTR_BYTES + 1);
  localparam int unsigned LANE_W      = $clog2(INSTR_BYTES);
  localparam int unsigned ASM_W       = 8 * (INSTR_BYTES - 1);

  localparam logic [31:0] FAULT_INSTR = 32'h0;

endpackage

// File: rtl/imem_port_arbiter.sv
// Grants the shared memory port to load or fetch; load wins unless fetch has starved.
module imem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic idle_i,
  input  logic fetch_req_i,
  input  logic load_valid_i,
  output logic fetch_ready_o,
  output logic load_ready_o
);

  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

  logic [STARVE_W-1:0] starve_q;
  logic [STARVE_W-1:0] starve_d;
  logic                starved;

  // Grant equations and saturating starve count of denied fetch cycles.
  always_comb begin
    starved       = (starve_q == STARVE_W'(STARVE_MAX));
    fetch_ready_o = idle_i && (!load_valid_i || starved);
    load_ready_o  = idle_i && !(fetch_req_i && starved);
    starve_d      = '0;
    if (fetch_req_i && !fetch_ready_o) begin
      starve_d = starved ? starve_q : starve_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/imem_fetch_sequencer.sv
// Fetches a 32-bit instruction as four byte reads from a single-port memory,
// sharing the port with a byte-wide program loader.
module imem_fetch_sequencer
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W     = IMEM_ADDR_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [63:0]       fetch_pc,
  output logic              fetch_ready,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic              fetch_fault,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              load_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  state_e              state_q;
  logic [ADDR_W-1:0]   base_q;
  logic [ISSUE_W-1:0]  issue_q;
  logic [LANE_W-1:0]   lane_q;
  logic [ASM_W-1:0]    asm_q;
  logic                instr_valid_q;
  logic [31:0]         instr_q;
  logic                fault_q;

  logic                idle;
  logic                fetch_go;
  logic                load_go;
  logic                pc_bad;
  logic                issuing;

  assign idle     = (state_q == IDLE);
  assign fetch_go = fetch_req && fetch_ready;
  assign load_go  = load_valid && load_ready;
  assign pc_bad   = (fetch_pc[1:0] != 2'b00) || (fetch_pc[63:ADDR_W] != '0);
  assign issuing  = (state_q == FETCH) && (issue_q < ISSUE_W'(INSTR_BYTES));

  imem_port_arbiter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk          (clk),
    .reset        (reset),
    .idle_i       (idle),
    .fetch_req_i  (fetch_req),
    .load_valid_i (load_valid),
    .fetch_ready_o(fetch_ready),
    .load_ready_o (load_ready)
  );

  // Memory port mux: loader writes pass straight through, fetch issues come from registers.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (load_go) begin
      mem_addr  = load_addr;
      mem_we    = 1'b1;
      mem_wdata = load_data;
    end else if (issuing) begin
      mem_addr = base_q + ADDR_W'(issue_q);
    end
  end

  // Sequencer FSM; read data lags the issued address by one cycle, so capture starts one edge late.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      base_q        <= '0;
      issue_q       <= '0;
      lane_q        <= '0;
      asm_q         <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      fault_q       <= 1'b0;
    end else begin
      instr_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fetch_go) begin
            base_q  <= fetch_pc[ADDR_W-1:0];
            issue_q <= '0;
            lane_q  <= '0;
            state_q <= pc_bad ? FAULT : FETCH;
          end
        end
        FETCH: begin
          if (issuing) begin
            issue_q <= issue_q + ISSUE_W'(1);
          end
          if (issue_q != '0) begin
            lane_q <= lane_q + LANE_W'(1);
            if (lane_q == LANE_W'(INSTR_BYTES - 1)) begin
              instr_q       <= {asm_q, mem_rdata};
              fault_q       <= 1'b0;
              instr_valid_q <= 1'b1;
              state_q       <= IDLE;
            end else begin
              asm_q <= {asm_q[ASM_W-9:0], mem_rdata};
            end
          end
        end
        FAULT: begin
          instr_q       <= FAULT_INSTR;
          fault_q       <= 1'b1;
          instr_valid_q <= 1'b1;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign fetch_fault = fault_q;
  assign busy        = !idle;

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Scoreboard bench for imem_fetch_sequencer with a registered-read byte memory model.
module tb_imem_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [63:0] fetch_pc;
  logic        fetch_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic        fetch_fault;
  logic        load_valid;
  logic [5:0]  load_addr;
  logic [7:0]  load_data;
  logic        load_ready;
  logic [5:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;

  typedef struct {
    logic [31:0] instr;
    logic        fault;
    int          due;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model [64];
  logic [7:0] imem  [64];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;

  imem_fetch_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_req  (fetch_req),
    .fetch_pc   (fetch_pc),
    .fetch_ready(fetch_ready),
    .instr_valid(instr_valid),
    .instr      (instr),
    .fetch_fault(fetch_fault),
    .load_valid (load_valid),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_ready (load_ready),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port byte memory, read data registered.
  always @(posedge clk) begin
    if (mem_we) imem[mem_addr] <= mem_wdata;
    mem_rdata <= imem[mem_addr];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t expect_for(input logic [63:0] pc);
    exp_t e;
    int   b;
    b = int'(pc[5:0]);
    if (pc[1:0] != 2'b00 || pc[63:6] != '0) begin
      e.instr = 32'h0;
      e.fault = 1'b1;
    end else begin
      e.instr = {model[b], model[b+1], model[b+2], model[b+3]};
      e.fault = 1'b0;
    end
    e.due = 0;
    return e;
  endfunction

  // Raise fetch_req until accepted; push the expected result with its due cycle.
  task automatic start_fetch(input logic [63:0] pc, output bit ok);
    exp_t e;
    ok = 1'b0;
    fetch_req = 1'b1;
    fetch_pc  = pc;
    for (int n = 0; n < 32 && !ok; n++) begin
      #1;
      if (fetch_ready) begin
        e     = expect_for(pc);
        e.due = cyc + 1 + (e.fault ? 1 : 5);
        sb.push_back(e);
        ok = 1'b1;
      end
      tick();
    end
    fetch_req = 1'b0;
  endtask

  task automatic wait_valid(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 24 && !seen; n++) begin
      if (instr_valid) seen = 1'b1;
      else tick();
    end
  endtask

  task automatic load_byte(input logic [5:0] a, input logic [7:0] d);
    bit done;
    done = 1'b0;
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    for (int n = 0; n < 16 && !done; n++) begin
      #1;
      if (load_ready) begin
        model[a] = d;
        done = 1'b1;
      end
      tick();
    end
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; fetch_req = 1'b0; fetch_pc = '0;
    load_valid = 1'b0; load_addr = '0; load_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({instr_valid, instr, fetch_fault, busy} !== 35'h0) begin
      $display("FAIL reset_status: valid=%0b instr=%h fault=%0b busy=%0b, required all 0",
               instr_valid, instr, fetch_fault, busy);
      failures++;
    end
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== 15'h0) begin
      $display("FAIL reset_mem: we=%0b addr=%0d wdata=%h, required 0/0/00", mem_we, mem_addr, mem_wdata);
      failures++;
    end
    reset = 1'b0;
    tick();
    checks++;
    if (fetch_ready !== 1'b1 || load_ready !== 1'b1) begin
      $display("FAIL reset_ready: fetch_ready=%0b load_ready=%0b, required 1/1", fetch_ready, load_ready);
      failures++;
    end
  endtask

  task automatic test_single_fetch();
    bit   ok, seen;
    exp_t e;
    logic [31:0] held;
    load_byte(6'd0, 8'hF8); load_byte(6'd1, 8'h42);
    load_byte(6'd2, 8'h80); load_byte(6'd3, 8'h2A);
    start_fetch(64'd0, ok);
    checks++;
    if (!ok || busy !== 1'b1) begin
      $display("FAIL single_accept: accepted=%0b busy=%0b, required 1/1", ok, busy);
      failures++;
    end
    wait_valid(seen);
    checks++;
    if (!seen || sb.size() == 0) begin
      $display("FAIL single_pulse: seen=%0b pending=%0d, required pulse with pending entry", seen, sb.size());
      failures++;
    end else begin
      e = sb.pop_front();
      checks++;
      if (instr !== 32'hF842802A || instr !== e.instr || fetch_fault !== e.fault) begin
        $display("FAIL single_data: instr=%h fault=%0b, required %h/%0b", instr, fetch_fault, e.instr, e.fault);
        failures++;
      end
      checks++;
      if (cyc != e.due) begin
        $display("FAIL single_latency: pulse cycle=%0d, required %0d", cyc, e.due);
        failures++;
      end
    end
    held = instr;
    tick();
    checks++;
    if (instr_valid !== 1'b0 || instr !== held || busy !== 1'b0) begin
      $display("FAIL single_after: valid=%0b instr=%h busy=%0b, required 0/%h/0", instr_valid, instr, busy, held);
      failures++;
    end
  endtask

  task automatic test_back_to_back();
    bit   ok, seen;
    exp_t e;
    load_byte(6'd20, 8'hCB); load_byte(6'd21, 8'h03);
    load_byte(6'd22, 8'h00); load_byte(6'd23, 8'h22);
    start_fetch(64'd20, ok);
    fetch_req = 1'b1;
    fetch_pc  = 64'd0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem_addr !== 6'(20 + k) || mem_we !== 1'b0) begin
        $display("FAIL b2b_issue%0d: mem_addr=%0d we=%0b, required %0d/0", k, mem_addr, mem_we, 20 + k);
        failures++;
      end
      tick();
    end
    wait_valid(seen);
    checks++;
    if (!ok || !seen || sb.size() == 0) begin
      $display("FAIL b2b_first_pulse: accepted=%0b seen=%0b pending=%0d, required 1/1/>0", ok, seen, sb.size());
      failures++;
    end else begin
      e = sb.pop_front();
      checks++;
      if (instr !== 32'hCB030022 || instr !== e.instr || fetch_fault !== 1'b0 || cyc != e.due) begin
        $display("FAIL b2b_first: instr=%h fault=%0b cycle=%0d, required %h/0/%0d", instr, fetch_fault, cyc, e.instr, e.due);
        failures++;
      end
    end
    checks++;
    if (fetch_ready !== 1'b1) begin
      $display("FAIL b2b_ready_in_pulse: fetch_ready=%0b, required 1", fetch_ready);
      failures++;
    end
    e     = expect_for(64'd0);
    e.due = cyc + 6;
    sb.push_back(e);
    tick();
    fetch_req = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      $display("FAIL b2b_second_accept: busy=%0b, required 1", busy);
      failures++;
    end
    wait_valid(seen);
    checks++;
    if (!seen || sb.size() == 0) begin
      $display("FAIL b2b_second_pulse: seen=%0b pending=%0d, required 1/>0", seen, sb.size());
      failures++;
    end else begin
      e = sb.pop_front();
      checks++;
      if (instr !== 32'hF842802A || instr !== e.instr || fetch_fault !== 1'b0 || cyc != e.due) begin
        $display("FAIL b2b_second: instr=%h fault=%0b cycle=%0d, required %h/0/%0d", instr, fetch_fault, cyc, e.instr, e.due);
        failures++;
      end
    end
    tick();
  endtask

  task automatic test_fault();
    logic [63:0] pcs [3];
    bit   ok, seen;
    exp_t e;
    pcs[0] = 64'd2; pcs[1] = 64'd64; pcs[2] = 64'h8000_0000_0000_0004;
    for (int p = 0; p < 3; p++) begin
      start_fetch(pcs[p], ok);
      checks++;
      if (!ok || busy !== 1'b1 || mem_addr !== 6'd0 || mem_we !== 1'b0) begin
        $display("FAIL fault_quiet%0d: accepted=%0b busy=%0b mem_addr=%0d we=%0b, required 1/1/0/0",
                 p, ok, busy, mem_addr, mem_we);
        failures++;
      end
      wait_valid(seen);
      checks++;
      if (!seen || sb.size() == 0) begin
        $display("FAIL fault_pulse%0d: seen=%0b pending=%0d, required 1/>0", p, seen, sb.size());
        failures++;
      end else begin
        e = sb.pop_front();
        checks++;
        if (instr !== 32'h0 || fetch_fault !== 1'b1 || e.fault !== 1'b1 || cyc != e.due) begin
          $display("FAIL fault_result%0d: instr=%h fault=%0b cycle=%0d, required 00000000/1/%0d",
                   p, instr, fetch_fault, cyc, e.due);
          failures++;
        end
      end
      tick();
    end
  endtask

  task automatic test_starve();
    int   li;
    bit   acc, exp_lr, exp_fr;
    exp_t e;
    li = 0; acc = 1'b0;
    fetch_req = 1'b1;
    fetch_pc  = 64'd0;
    for (int t = 0; t < 14; t++) begin
      load_valid = (li < 8);
      load_addr  = 6'(40 + li);
      load_data  = 8'(8'h10 + li);
      #1;
      exp_lr = (t < 4) || (t >= 10);
      exp_fr = (t == 4);
      checks++;
      if (load_ready !== exp_lr || fetch_ready !== exp_fr) begin
        $display("FAIL starve_grant t=%0d: load_ready=%0b fetch_ready=%0b, required %0b/%0b",
                 t, load_ready, fetch_ready, exp_lr, exp_fr);
        failures++;
      end
      checks++;
      if (instr_valid !== (t == 10)) begin
        $display("FAIL starve_valid t=%0d: instr_valid=%0b, required %0b", t, instr_valid, (t == 10));
        failures++;
      end
      if (instr_valid && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (instr !== e.instr || fetch_fault !== e.fault || cyc != e.due) begin
          $display("FAIL starve_data: instr=%h fault=%0b cycle=%0d, required %h/%0b/%0d",
                   instr, fetch_fault, cyc, e.instr, e.fault, e.due);
          failures++;
        end
      end
      if (fetch_req && fetch_ready) begin
        e     = expect_for(64'd0);
        e.due = cyc + 6;
        sb.push_back(e);
        acc = 1'b1;
      end
      if (load_valid && load_ready) begin
        model[40 + li] = load_data;
        li++;
      end
      tick();
      if (acc) fetch_req = 1'b0;
    end
    load_valid = 1'b0;
    checks++;
    if (li != 8) begin
      $display("FAIL starve_load_count: granted=%0d, required 8", li);
      failures++;
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (imem[40 + k] !== 8'(8'h10 + k)) begin
        $display("FAIL starve_mem%0d: mem=%h, required %h", k, imem[40 + k], 8'(8'h10 + k));
        failures++;
      end
    end
  endtask

  task automatic test_load_then_fetch();
    bit   ok, seen;
    exp_t e;
    load_byte(6'd4, 8'h11); load_byte(6'd5, 8'h22); load_byte(6'd6, 8'h33);
    load_valid = 1'b1; load_addr = 6'd7; load_data = 8'h5A;
    #1;
    checks++;
    if (load_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 6'd7 || mem_wdata !== 8'h5A) begin
      $display("FAIL load_passthru: ready=%0b we=%0b addr=%0d wdata=%h, required 1/1/7/5a",
               load_ready, mem_we, mem_addr, mem_wdata);
      failures++;
    end
    model[7] = 8'h5A;
    tick();
    load_valid = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== 6'd0 || mem_wdata !== 8'h00) begin
      $display("FAIL load_idle: we=%0b addr=%0d wdata=%h, required 0/0/00", mem_we, mem_addr, mem_wdata);
      failures++;
    end
    tick();
    start_fetch(64'd4, ok);
    load_valid = 1'b1; load_addr = 6'd9; load_data = 8'hEE;
    #1;
    checks++;
    if (!ok || load_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 6'd4) begin
      $display("FAIL load_midfetch: accepted=%0b load_ready=%0b we=%0b addr=%0d, required 1/0/0/4",
               ok, load_ready, mem_we, mem_addr);
      failures++;
    end
    tick();
    load_valid = 1'b0;
    wait_valid(seen);
    checks++;
    if (!seen || sb.size() == 0) begin
      $display("FAIL ltf_pulse: seen=%0b pending=%0d, required 1/>0", seen, sb.size());
      failures++;
    end else begin
      e = sb.pop_front();
      checks++;
      if (instr !== e.instr || instr[7:0] !== 8'h5A || fetch_fault !== 1'b0 || cyc != e.due) begin
        $display("FAIL ltf_data: instr=%h fault=%0b cycle=%0d, required %h/0/%0d", instr, fetch_fault, cyc, e.instr, e.due);
        failures++;
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_fetch();
    bit   ok, seen, stray;
    exp_t e;
    start_fetch(64'd0, ok);
    tick();
    tick();
    reset = 1'b1;
    tick();
    sb.delete();
    checks++;
    if (!ok || {instr_valid, instr, fetch_fault, busy, mem_we, mem_addr, mem_wdata} !== 50'h0) begin
      $display("FAIL rst_mid_outputs: accepted=%0b valid=%0b instr=%h fault=%0b busy=%0b we=%0b addr=%0d wdata=%h, required all 0",
               ok, instr_valid, instr, fetch_fault, busy, mem_we, mem_addr, mem_wdata);
      failures++;
    end
    reset = 1'b0;
    stray = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (instr_valid) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      $display("FAIL rst_mid_stray: instr_valid pulsed after reset, required none");
      failures++;
    end
    start_fetch(64'd20, ok);
    wait_valid(seen);
    checks++;
    if (!ok || !seen || sb.size() == 0) begin
      $display("FAIL rst_fresh_pulse: accepted=%0b seen=%0b pending=%0d, required 1/1/>0", ok, seen, sb.size());
      failures++;
    end else begin
      e = sb.pop_front();
      checks++;
      if (instr !== 32'hCB030022 || instr !== e.instr || fetch_fault !== 1'b0 || cyc != e.due) begin
        $display("FAIL rst_fresh_data: instr=%h fault=%0b cycle=%0d, required %h/0/%0d", instr, fetch_fault, cyc, e.instr, e.due);
        failures++;
      end
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) model[i] = 8'h00;
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_fault();
    test_starve();
    test_load_then_fetch();
    test_reset_mid_fetch();
    checks++;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: pending=%0d, required 0", sb.size());
      failures++;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
